wb_xcpt_tracker: RTL and testbench

WB_XCPT_TRACKER -- requirements
Module: wb_xcpt_tracker

---
 rtl/wb_xcpt_tracker_pkg.sv | 40 ++++
 rtl/wb_xcpt_classify.sv | 25 ++
 rtl/wb_xcpt_tracker.sv | 118 +++++++++++
 tb/tb_wb_xcpt_tracker.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_xcpt_tracker_pkg.sv
// Shared definitions for the writeback exception tracker: cause codes,
// flag bit positions and the held exception record.
package wb_xcpt_tracker_pkg;

    localparam int XCPT_ROB_IDX_W = 3;
    localparam int XCPT_ADDR_W    = 32;
    localparam int CAUSE_W        = 3;
    localparam int NUM_CAUSES     = 8;
    localparam int CNT_W          = 16;

    localparam logic [CAUSE_W-1:0] CAUSE_ITLB_MISS     = 3'b000;
    localparam logic [CAUSE_W-1:0] CAUSE_FETCH_BUS_ERR = 3'b001;
    localparam logic [CAUSE_W-1:0] CAUSE_ILLEGAL       = 3'b010;
    localparam logic [CAUSE_W-1:0] CAUSE_OVERFLOW      = 3'b011;
    localparam logic [CAUSE_W-1:0] CAUSE_DTLB_MISS     = 3'b100;
    localparam logic [CAUSE_W-1:0] CAUSE_BUS_ERR       = 3'b101;
    localparam logic [CAUSE_W-1:0] CAUSE_ADDR_FAULT    = 3'b110;

    localparam int FLAG_ITLB_MISS     = 0;
    localparam int FLAG_FETCH_BUS_ERR = 1;
    localparam int FLAG_ILLEGAL       = 2;
    localparam int FLAG_ALU_OVF       = 3;
    localparam int FLAG_MUL_OVF       = 4;
    localparam int FLAG_ADDR_FAULT    = 5;
    localparam int FLAG_DTLB_MISS     = 6;
    localparam int FLAG_BUS_ERR       = 7;

    // Record widths are fixed here; the tracker's parameter defaults match them.
    typedef struct packed {
        logic [XCPT_ROB_IDX_W-1:0] rob_idx;
        logic [CAUSE_W-1:0]        cause;
        logic [XCPT_ADDR_W-1:0]    pc;
        logic [XCPT_ADDR_W-1:0]    addr;
    } xcpt_rec_t;

    function automatic logic causeHasAddr(input logic [CAUSE_W-1:0] cause);
        return !((cause == CAUSE_ILLEGAL) || (cause == CAUSE_OVERFLOW));
    endfunction

endpackage

// File: rtl/wb_xcpt_classify.sv
// Per-channel flag-to-cause priority encoder; also reports whether the
// resulting cause carries a faulting address.
module wb_xcpt_classify
    import wb_xcpt_tracker_pkg::*;
(
    input  logic [7:0]         flags,
    output logic               hit,
    output logic [CAUSE_W-1:0] cause,
    output logic               useAddr
);

    always_comb begin
        hit   = |flags;
        cause = CAUSE_ITLB_MISS;
        if (flags[FLAG_ITLB_MISS])               cause = CAUSE_ITLB_MISS;
        else if (flags[FLAG_FETCH_BUS_ERR])      cause = CAUSE_FETCH_BUS_ERR;
        else if (flags[FLAG_ILLEGAL])            cause = CAUSE_ILLEGAL;
        else if (flags[FLAG_ALU_OVF] || flags[FLAG_MUL_OVF]) cause = CAUSE_OVERFLOW;
        else if (flags[FLAG_ADDR_FAULT])         cause = CAUSE_ADDR_FAULT;
        else if (flags[FLAG_DTLB_MISS])          cause = CAUSE_DTLB_MISS;
        else if (flags[FLAG_BUS_ERR])            cause = CAUSE_BUS_ERR;
        useAddr = causeHasAddr(cause);
    end

endmodule

// File: rtl/wb_xcpt_tracker.sv
// Holds the oldest writeback exception until the ROB acks it or a flush hits.
// Optional feature macro XCPT_CAUSE_CNT_EN adds per-cause saturating ack counters.
module wb_xcpt_tracker
    import wb_xcpt_tracker_pkg::*;
#(
    parameter int NUM_CH    = 3,
    parameter int ROB_IDX_W = XCPT_ROB_IDX_W,
    parameter int ADDR_W    = XCPT_ADDR_W
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [NUM_CH-1:0]           wb_valid,
    input  logic [NUM_CH*ROB_IDX_W-1:0] wb_rob_idx,
    input  logic [NUM_CH*8-1:0]         wb_xcpt_flags,
    input  logic [NUM_CH*ADDR_W-1:0]    wb_pc,
    input  logic [NUM_CH*ADDR_W-1:0]    wb_addr,
    input  logic [ROB_IDX_W-1:0]        rob_head_idx,
    input  logic                        flush,
    input  logic                        xcpt_ack,
    output logic                        xcpt_valid,
    output logic [ROB_IDX_W-1:0]        xcpt_rob_idx,
    output logic [CAUSE_W-1:0]          xcpt_cause,
    output logic [ADDR_W-1:0]           xcpt_pc,
    output logic [ADDR_W-1:0]           xcpt_addr
`ifdef XCPT_CAUSE_CNT_EN
   ,output logic [NUM_CAUSES*CNT_W-1:0] xcpt_cnt
`endif
);

    logic [NUM_CH-1:0]  chHit;
    logic [CAUSE_W-1:0] chCause [NUM_CH];
    logic               chUseAddr [NUM_CH];

    for (genvar c = 0; c < NUM_CH; c++) begin : g_cls
        wb_xcpt_classify u_classify (
            .flags   (wb_xcpt_flags[c*8 +: 8]),
            .hit     (chHit[c]),
            .cause   (chCause[c]),
            .useAddr (chUseAddr[c])
        );
    end

    logic                 valid_q, valid_d;
    xcpt_rec_t            held_q, held_d;
    logic                 winValid;
    logic [ROB_IDX_W-1:0] winAge, chAge, heldAge;
    xcpt_rec_t            winRec;
    logic                 ackTaken;

    // Strict less-than keeps the lowest channel on equal age.
    always_comb begin
        winValid = 1'b0;
        winAge   = '0;
        winRec   = '0;
        chAge    = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            chAge = wb_rob_idx[c*ROB_IDX_W +: ROB_IDX_W] - rob_head_idx;
            if (wb_valid[c] && chHit[c] && (!winValid || (chAge < winAge))) begin
                winValid       = 1'b1;
                winAge         = chAge;
                winRec.rob_idx = XCPT_ROB_IDX_W'(wb_rob_idx[c*ROB_IDX_W +: ROB_IDX_W]);
                winRec.cause   = chCause[c];
                winRec.pc      = XCPT_ADDR_W'(wb_pc[c*ADDR_W +: ADDR_W]);
                winRec.addr    = chUseAddr[c] ? XCPT_ADDR_W'(wb_addr[c*ADDR_W +: ADDR_W]) : '0;
            end
        end
    end

    always_comb begin
        heldAge  = ROB_IDX_W'(held_q.rob_idx) - rob_head_idx;
        ackTaken = xcpt_ack && valid_q && !flush;
        valid_d  = valid_q;
        held_d   = held_q;
        if (flush) begin
            valid_d = 1'b0;
            held_d  = '0;
        end else if (winValid && (!valid_q || xcpt_ack || (winAge < heldAge))) begin
            valid_d = 1'b1;
            held_d  = winRec;
        end else if (ackTaken) begin
            valid_d = 1'b0;
            held_d  = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= 1'b0;
            held_q  <= '0;
        end else begin
            valid_q <= valid_d;
            held_q  <= held_d;
        end
    end

    assign xcpt_valid   = valid_q;
    assign xcpt_rob_idx = ROB_IDX_W'(held_q.rob_idx);
    assign xcpt_cause   = held_q.cause;
    assign xcpt_pc      = ADDR_W'(held_q.pc);
    assign xcpt_addr    = ADDR_W'(held_q.addr);

`ifdef XCPT_CAUSE_CNT_EN
    logic [CNT_W-1:0] cnt_q [NUM_CAUSES];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < NUM_CAUSES; k++) cnt_q[k] <= '0;
        end else if (ackTaken && (cnt_q[held_q.cause] != {CNT_W{1'b1}})) begin
            cnt_q[held_q.cause] <= cnt_q[held_q.cause] + 1'b1;
        end
    end

    for (genvar k = 0; k < NUM_CAUSES; k++) begin : g_cnt
        assign xcpt_cnt[k*CNT_W +: CNT_W] = cnt_q[k];
    end
`endif

endmodule

// File: tb/tb_wb_xcpt_tracker.sv
// Directed self-checking bench for wb_xcpt_tracker; the counter scenario is
// compiled in only when XCPT_CAUSE_CNT_EN is defined.
module tb_wb_xcpt_tracker;

    localparam int NUM_CH    = 3;
    localparam int ROB_IDX_W = 3;
    localparam int ADDR_W    = 32;

    logic                        clock = 1'b0;
    logic                        reset;
    logic [NUM_CH-1:0]           wb_valid;
    logic [NUM_CH*ROB_IDX_W-1:0] wb_rob_idx;
    logic [NUM_CH*8-1:0]         wb_xcpt_flags;
    logic [NUM_CH*ADDR_W-1:0]    wb_pc;
    logic [NUM_CH*ADDR_W-1:0]    wb_addr;
    logic [ROB_IDX_W-1:0]        rob_head_idx;
    logic                        flush;
    logic                        xcpt_ack;
    logic                        xcpt_valid;
    logic [ROB_IDX_W-1:0]        xcpt_rob_idx;
    logic [2:0]                  xcpt_cause;
    logic [ADDR_W-1:0]           xcpt_pc;
    logic [ADDR_W-1:0]           xcpt_addr;
`ifdef XCPT_CAUSE_CNT_EN
    logic [8*16-1:0]             xcpt_cnt;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    wb_xcpt_tracker #(
        .NUM_CH    (NUM_CH),
        .ROB_IDX_W (ROB_IDX_W),
        .ADDR_W    (ADDR_W)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .wb_valid      (wb_valid),
        .wb_rob_idx    (wb_rob_idx),
        .wb_xcpt_flags (wb_xcpt_flags),
        .wb_pc         (wb_pc),
        .wb_addr       (wb_addr),
        .rob_head_idx  (rob_head_idx),
        .flush         (flush),
        .xcpt_ack      (xcpt_ack),
        .xcpt_valid    (xcpt_valid),
        .xcpt_rob_idx  (xcpt_rob_idx),
        .xcpt_cause    (xcpt_cause),
        .xcpt_pc       (xcpt_pc),
        .xcpt_addr     (xcpt_addr)
`ifdef XCPT_CAUSE_CNT_EN
       ,.xcpt_cnt      (xcpt_cnt)
`endif
    );

    task automatic clearInputs();
        wb_valid      = '0;
        wb_rob_idx    = '0;
        wb_xcpt_flags = '0;
        wb_pc         = '0;
        wb_addr       = '0;
        flush         = 1'b0;
        xcpt_ack      = 1'b0;
    endtask

    task automatic applyStimulus(input int ch, input logic [2:0] idx, input logic [7:0] flags,
                                 input logic [31:0] pc, input logic [31:0] addr);
        wb_valid[ch]               = 1'b1;
        wb_rob_idx[ch*3 +: 3]      = idx;
        wb_xcpt_flags[ch*8 +: 8]   = flags;
        wb_pc[ch*32 +: 32]         = pc;
        wb_addr[ch*32 +: 32]       = addr;
    endtask

    // Inputs are changed 1 time unit after a rising edge and outputs read there too.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic flushAll();
        clearInputs();
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    task automatic test_reset();
        clearInputs();
        rob_head_idx = 3'd0;
        reset = 1'b1;
        applyStimulus(0, 3'd4, 8'h80, 32'h1111_0000, 32'h2222_0000);
        step();
        step();
        total++; if (xcpt_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got=%0h exp=0", xcpt_valid); end
        total++; if (xcpt_rob_idx !== 3'd0) begin bad++; $display("[TB] FAIL reset_idx got=%0h exp=0", xcpt_rob_idx); end
        total++; if (xcpt_cause !== 3'd0) begin bad++; $display("[TB] FAIL reset_cause got=%0h exp=0", xcpt_cause); end
        total++; if (xcpt_pc !== 32'd0) begin bad++; $display("[TB] FAIL reset_pc got=%0h exp=0", xcpt_pc); end
        total++; if (xcpt_addr !== 32'd0) begin bad++; $display("[TB] FAIL reset_addr got=%0h exp=0", xcpt_addr); end
`ifdef XCPT_CAUSE_CNT_EN
        total++; if (xcpt_cnt !== '0) begin bad++; $display("[TB] FAIL reset_cnt got=%0h exp=0", xcpt_cnt); end
`endif
        reset = 1'b0;
        clearInputs();
        step();
    endtask

    task automatic test_priority();
        logic [7:0] flagTab  [8] = '{8'h41, 8'h06, 8'h0C, 8'h18, 8'h10, 8'hE0, 8'hC0, 8'h80};
        logic [2:0] causeTab [8] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b011, 3'b110, 3'b100, 3'b101};
        logic       addrTab  [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [31:0] expAddr;
        for (int i = 0; i < 8; i++) begin
            flushAll();
            rob_head_idx = 3'd0;
            applyStimulus(0, 3'd2, flagTab[i], 32'h0000_1000 + 32'(i), 32'hDEAD_0000 + 32'(i));
            step();
            clearInputs();
            expAddr = addrTab[i] ? (32'hDEAD_0000 + 32'(i)) : 32'd0;
            total++; if (xcpt_valid !== 1'b1) begin bad++; $display("[TB] FAIL prio_valid[%0d] got=%0h exp=1", i, xcpt_valid); end
            total++; if (xcpt_cause !== causeTab[i]) begin bad++; $display("[TB] FAIL prio_cause[%0d] got=%0h exp=%0h", i, xcpt_cause, causeTab[i]); end
            total++; if (xcpt_rob_idx !== 3'd2) begin bad++; $display("[TB] FAIL prio_idx[%0d] got=%0h exp=2", i, xcpt_rob_idx); end
            total++; if (xcpt_pc !== 32'h0000_1000 + 32'(i)) begin bad++; $display("[TB] FAIL prio_pc[%0d] got=%0h", i, xcpt_pc); end
            total++; if (xcpt_addr !== expAddr) begin bad++; $display("[TB] FAIL prio_addr[%0d] got=%0h exp=%0h", i, xcpt_addr, expAddr); end
        end
        step();
        total++; if (xcpt_valid !== 1'b1 || xcpt_cause !== 3'b101 || xcpt_rob_idx !== 3'd2) begin
            bad++; $display("[TB] FAIL hold_stable got v=%0h c=%0h i=%0h exp v=1 c=5 i=2", xcpt_valid, xcpt_cause, xcpt_rob_idx);
        end
    endtask

    task automatic test_oldest();
        flushAll();
        rob_head_idx = 3'd5;
        applyStimulus(1, 3'd7, 8'h08, 32'hA000_0001, 32'hB000_0001);
        applyStimulus(2, 3'd6, 8'h80, 32'hA000_0002, 32'hB000_0002);
        step();
        clearInputs();
        total++; if (xcpt_rob_idx !== 3'd6) begin bad++; $display("[TB] FAIL oldest_idx got=%0h exp=6", xcpt_rob_idx); end
        total++; if (xcpt_cause !== 3'b101) begin bad++; $display("[TB] FAIL oldest_cause got=%0h exp=5", xcpt_cause); end
        total++; if (xcpt_addr !== 32'hB000_0002) begin bad++; $display("[TB] FAIL oldest_addr got=%0h exp=b0000002", xcpt_addr); end
        flushAll();
        applyStimulus(0, 3'd3, 8'h04, 32'hC000_0000, 32'h0);
        applyStimulus(2, 3'd3, 8'h80, 32'hC000_0002, 32'hD000_0002);
        step();
        clearInputs();
        total++; if (xcpt_cause !== 3'b010 || xcpt_pc !== 32'hC000_0000) begin
            bad++; $display("[TB] FAIL tie_lowest_ch got c=%0h pc=%0h exp c=2 pc=c0000000", xcpt_cause, xcpt_pc);
        end
    endtask

    task automatic test_older_replaces();
        flushAll();
        rob_head_idx = 3'd2;
        applyStimulus(0, 3'd3, 8'h80, 32'h0000_3000, 32'h0000_3333);
        step();
        clearInputs();
        applyStimulus(0, 3'd2, 8'h04, 32'h0000_2000, 32'h0000_2222);
        step();
        clearInputs();
        total++; if (xcpt_rob_idx !== 3'd2 || xcpt_cause !== 3'b010 || xcpt_addr !== 32'd0) begin
            bad++; $display("[TB] FAIL older_replace got i=%0h c=%0h a=%0h exp i=2 c=2 a=0", xcpt_rob_idx, xcpt_cause, xcpt_addr);
        end
        applyStimulus(1, 3'd4, 8'h01, 32'h0000_4000, 32'h0000_4444);
        step();
        clearInputs();
        total++; if (xcpt_rob_idx !== 3'd2) begin bad++; $display("[TB] FAIL younger_kept got=%0h exp=2", xcpt_rob_idx); end
        applyStimulus(1, 3'd2, 8'h01, 32'h0000_5000, 32'h0000_5555);
        step();
        clearInputs();
        total++; if (xcpt_cause !== 3'b010 || xcpt_pc !== 32'h0000_2000) begin
            bad++; $display("[TB] FAIL equal_age_kept got c=%0h pc=%0h exp c=2 pc=2000", xcpt_cause, xcpt_pc);
        end
    endtask

    task automatic test_ack_flush();
        xcpt_ack = 1'b1;
        step();
        clearInputs();
        total++; if (xcpt_valid !== 1'b0) begin bad++; $display("[TB] FAIL ack_clear got=%0h exp=0", xcpt_valid); end
        xcpt_ack = 1'b1;
        step();
        clearInputs();
        total++; if (xcpt_valid !== 1'b0) begin bad++; $display("[TB] FAIL ack_idle got=%0h exp=0", xcpt_valid); end
        rob_head_idx = 3'd2;
        applyStimulus(0, 3'd2, 8'h04, 32'h0000_2000, 32'h0);
        step();
        clearInputs();
        xcpt_ack = 1'b1;
        applyStimulus(1, 3'd5, 8'h40, 32'h0000_5000, 32'h0000_5A5A);
        step();
        clearInputs();
        total++; if (xcpt_valid !== 1'b1 || xcpt_rob_idx !== 3'd5 || xcpt_cause !== 3'b100) begin
            bad++; $display("[TB] FAIL ack_capture got v=%0h i=%0h c=%0h exp v=1 i=5 c=4", xcpt_valid, xcpt_rob_idx, xcpt_cause);
        end
        xcpt_ack = 1'b1;
        flush    = 1'b1;
        applyStimulus(0, 3'd2, 8'h01, 32'h0000_6000, 32'h0000_6666);
        step();
        clearInputs();
        total++; if (xcpt_valid !== 1'b0) begin bad++; $display("[TB] FAIL ack_flush_cand got=%0h exp=0", xcpt_valid); end
    endtask

    task automatic test_wrap();
        flushAll();
        rob_head_idx = 3'd6;
        applyStimulus(0, 3'd1, 8'h80, 32'h0000_0100, 32'h0000_0111);
        step();
        clearInputs();
        applyStimulus(2, 3'd7, 8'h02, 32'h0000_0700, 32'h0000_0777);
        step();
        clearInputs();
        total++; if (xcpt_rob_idx !== 3'd7 || xcpt_cause !== 3'b001) begin
            bad++; $display("[TB] FAIL wrap_replace got i=%0h c=%0h exp i=7 c=1", xcpt_rob_idx, xcpt_cause);
        end
        rob_head_idx = 3'd1;
        applyStimulus(1, 3'd5, 8'h20, 32'h0000_0500, 32'h0000_0555);
        step();
        clearInputs();
        total++; if (xcpt_rob_idx !== 3'd5 || xcpt_addr !== 32'h0000_0555) begin
            bad++; $display("[TB] FAIL head_moved_age got i=%0h a=%0h exp i=5 a=555", xcpt_rob_idx, xcpt_addr);
        end
    endtask

    task automatic test_reset_midhold();
        reset    = 1'b1;
        xcpt_ack = 1'b1;
        applyStimulus(0, 3'd1, 8'h01, 32'h0000_0900, 32'h0000_0999);
        step();
        reset = 1'b0;
        clearInputs();
        total++; if (xcpt_valid !== 1'b0 || xcpt_pc !== 32'd0 || xcpt_rob_idx !== 3'd0) begin
            bad++; $display("[TB] FAIL reset_midhold got v=%0h pc=%0h i=%0h exp all 0", xcpt_valid, xcpt_pc, xcpt_rob_idx);
        end
    endtask

`ifdef XCPT_CAUSE_CNT_EN
    task automatic test_counters();
        rob_head_idx = 3'd0;
        applyStimulus(0, 3'd1, 8'h40, 32'h0, 32'h0000_0040);
        step();
        for (int i = 0; i < 2; i++) begin
            xcpt_ack = 1'b1;
            step();
        end
        clearInputs();
        xcpt_ack = 1'b1;
        step();
        clearInputs();
        total++; if (xcpt_cnt[4*16 +: 16] !== 16'd3) begin bad++; $display("[TB] FAIL cnt_three got=%0d exp=3", xcpt_cnt[4*16 +: 16]); end
        total++; if (xcpt_cnt[0 +: 16] !== 16'd0) begin bad++; $display("[TB] FAIL cnt_other got=%0d exp=0", xcpt_cnt[0 +: 16]); end
        applyStimulus(0, 3'd1, 8'h40, 32'h0, 32'h0000_0040);
        step();
        xcpt_ack = 1'b1;
        for (int i = 0; i < 65532; i++) step();
        total++; if (xcpt_cnt[4*16 +: 16] !== 16'hFFFF) begin bad++; $display("[TB] FAIL cnt_full got=%0h exp=ffff", xcpt_cnt[4*16 +: 16]); end
        step();
        clearInputs();
        total++; if (xcpt_cnt[4*16 +: 16] !== 16'hFFFF) begin bad++; $display("[TB] FAIL cnt_saturate got=%0h exp=ffff", xcpt_cnt[4*16 +: 16]); end
    endtask
`endif

    initial begin
        reset        = 1'b1;
        rob_head_idx = '0;
        clearInputs();
        test_reset();
        test_priority();
        test_oldest();
        test_older_replaces();
        test_ack_flush();
        test_wrap();
        test_reset_midhold();
`ifdef XCPT_CAUSE_CNT_EN
        test_counters();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
